// File: rtl/sig_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sig_frame_ctrl
//
// Purpose:
//   Frames a free-running radio sample stream (one I and one Q bit per antenna,
//   a new sample every cycle) into FRAME_LEN-sample frames for a correlator.
//   A run is started by a single-cycle start pulse and lasts either a fixed
//   number of frames or until a stop request, which always completes the
//   current frame first. The radio cannot be stalled, so when the correlator
//   back-pressures, incoming samples are discarded and counted.
//
// Ports:
//   sig_clk       in   clock, rising edge
//   rst_n         in   synchronous active-low reset
//   radio_i       in   [WIDTH]  raw in-phase bits, one sample per cycle
//   radio_q       in   [WIDTH]  raw quadrature bits
//   cfg_start_i   in   start-of-run pulse (ignored while running)
//   cfg_stop_i    in   stop request, effective at end of current frame
//   cfg_frames_i  in   [FBITS]  frames per run, 0 = continuous
//   sig_valid_o   out  sample valid to correlator
//   sig_ready_i   in   correlator ready
//   sig_last_o    out  final sample of a frame
//   sig_idata_o   out  [WIDTH]  I sample
//   sig_qdata_o   out  [WIDTH]  Q sample
//   busy_o        out  high while a run is active
//   done_o        out  one-cycle pulse when a run ends
//   frame_cnt_o   out  [FBITS]  frames completed in the current run
//   overrun_o     out  sticky: at least one radio sample was lost
//   drop_cnt_o    out  [16]     lost samples, saturating
// -----------------------------------------------------------------------------
module sig_frame_ctrl #(
   parameter int WIDTH     = 4,
   parameter int FRAME_LEN = 150,
   parameter int FBITS     = 8
) (
   input  logic             sig_clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] radio_i,
   input  logic [WIDTH-1:0] radio_q,
   input  logic             cfg_start_i,
   input  logic             cfg_stop_i,
   input  logic [FBITS-1:0] cfg_frames_i,
   output logic             sig_valid_o,
   input  logic             sig_ready_i,
   output logic             sig_last_o,
   output logic [WIDTH-1:0] sig_idata_o,
   output logic [WIDTH-1:0] sig_qdata_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [FBITS-1:0] frame_cnt_o,
   output logic             overrun_o,
   output logic [15:0]      drop_cnt_o
);

   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] idata_q, idata_d;
   logic [WIDTH-1:0] qdata_q, qdata_d;
   logic [15:0]      idx_q, idx_d;        // index the next loaded sample will carry
   logic [FBITS-1:0] frames_q, frames_d;  // frame quota latched at start
   logic [FBITS-1:0] frame_cnt_q, frame_cnt_d;
   logic             overrun_q, overrun_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic             stop_pend_q, stop_pend_d;
   logic             done_q, done_d;

   logic             in_run;
   logic             start;
   logic             xfer;
   logic             stall;
   logic             last_xfer;
   logic             stop_now;
   logic [FBITS-1:0] frame_cnt_inc;
   logic             quota_hit;
   logic             end_run;
   logic             load;
   logic [15:0]      idx_cur;

   assign in_run        = (state_q == RUN);
   assign start         = (state_q == IDLE) && cfg_start_i;
   assign xfer          = valid_q && sig_ready_i;
   assign stall         = valid_q && !sig_ready_i;
   assign last_xfer     = xfer && last_q;
   // A stop arriving on the very edge of the last transfer still ends the run.
   assign stop_now      = stop_pend_q || cfg_stop_i;
   assign frame_cnt_inc = frame_cnt_q + FBITS'(1);
   assign quota_hit     = (frames_q != '0) && (frame_cnt_inc == frames_q);
   assign end_run       = in_run && last_xfer && (stop_now || quota_hit);
   // The output register is refilled whenever it frees up, so consecutive
   // frames follow each other with no bubble.
   assign load          = start || (in_run && (!valid_q || xfer) && !end_run);
   // A start always begins a fresh frame at index 0.
   assign idx_cur       = start ? 16'd0 : idx_q;

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge sig_clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cfg_start_i) state_d = RUN;
         RUN:     if (end_run)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == RUN);
   end

   // ----------------------------------------------------------- datapath ---
   always_comb begin
      valid_d     = valid_q;
      last_d      = last_q;
      idata_d     = idata_q;
      qdata_d     = qdata_q;
      idx_d       = idx_q;
      frames_d    = frames_q;
      frame_cnt_d = frame_cnt_q;
      overrun_d   = overrun_q;
      drop_cnt_d  = drop_cnt_q;
      stop_pend_d = stop_pend_q;
      done_d      = end_run;

      if (start) begin
         frames_d    = cfg_frames_i;
         frame_cnt_d = '0;
         overrun_d   = 1'b0;
         drop_cnt_d  = '0;
         stop_pend_d = 1'b0;
      end

      if (in_run) begin
         if (cfg_stop_i) begin
            stop_pend_d = 1'b1;
         end
         if (last_xfer) begin
            frame_cnt_d = frame_cnt_inc;
         end
         // Held sample not accepted: this cycle's radio sample is lost.
         if (stall) begin
            overrun_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end
      end

      if (load) begin
         valid_d = 1'b1;
         last_d  = (idx_cur == LAST_IDX);
         idata_d = radio_i;
         qdata_d = radio_q;
         idx_d   = (idx_cur == LAST_IDX) ? 16'd0 : idx_cur + 16'd1;
      end else if (end_run) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge sig_clk) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         idata_q     <= '0;
         qdata_q     <= '0;
         idx_q       <= '0;
         frames_q    <= '0;
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
         drop_cnt_q  <= '0;
         stop_pend_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         last_q      <= last_d;
         idata_q     <= idata_d;
         qdata_q     <= qdata_d;
         idx_q       <= idx_d;
         frames_q    <= frames_d;
         frame_cnt_q <= frame_cnt_d;
         overrun_q   <= overrun_d;
         drop_cnt_q  <= drop_cnt_d;
         stop_pend_q <= stop_pend_d;
         done_q      <= done_d;
      end
   end

   assign sig_valid_o = valid_q;
   assign sig_last_o  = last_q;
   assign sig_idata_o = idata_q;
   assign sig_qdata_o = qdata_q;
   assign done_o      = done_q;
   assign frame_cnt_o = frame_cnt_q;
   assign overrun_o   = overrun_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/sig_frame_ctrl.md
SIG_FRAME_CTRL -- requirements
Module: sig_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of antennas, one I and one Q bit each.
REQ-002 SHALL have parameter FRAME_LEN, default 150: samples per frame; legal range 2..65535.
REQ-003 SHALL have parameter FBITS, default 8: width of the frame-count configuration and status.
REQ-004 SHALL have port sig_clk, input, 1: clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port radio_i, input, WIDTH: raw in-phase bits, a new sample every cycle, cannot be stalled.
REQ-007 SHALL have port radio_q, input, WIDTH: raw quadrature bits.
REQ-008 SHALL have port cfg_start_i, input, 1: start-of-run request; only a single-cycle pulse is legal.
REQ-009 SHALL have port cfg_stop_i, input, 1: stop request; takes effect at the end of the current frame.
REQ-010 SHALL have port cfg_frames_i, input, FBITS: frames per run; 0 = continuous; sampled only at start.
REQ-011 SHALL have port sig_valid_o, output, 1: sample valid to the correlator.
REQ-012 SHALL have port sig_ready_i, input, 1: correlator ready.
REQ-013 SHALL have port sig_last_o, output, 1: marks the final sample of a frame.
REQ-014 SHALL have port sig_idata_o, output, WIDTH: I sample.
REQ-015 SHALL have port sig_qdata_o, output, WIDTH: Q sample.
REQ-016 SHALL have port busy_o, output, 1: high while in RUN.
REQ-017 SHALL have port done_o, output, 1: one-cycle pulse at the end of a run.
REQ-018 SHALL have port frame_cnt_o, output, FBITS: frames completed in the current run.
REQ-019 SHALL have port overrun_o, output, 1: sticky flag, set when a radio sample is lost.
REQ-020 SHALL have port drop_cnt_o, output, 16: number of lost samples, saturating.

Function
REQ-021 SHALL implement a two-state FSM: IDLE and RUN.
REQ-022 In IDLE, cfg_start_i high SHALL, at that edge:
- enter RUN;
- latch cfg_frames_i;
- clear frame_cnt_o, overrun_o, drop_cnt_o and the stop-pending flag;
- load {radio_i, radio_q} into the output register with sig_valid_o=1 and sample index 0.
REQ-023 Latency from the cfg_start_i edge to the first sig_valid_o is therefore one cycle.
REQ-024 cfg_start_i in RUN, and cfg_stop_i in IDLE, SHALL be ignored.
REQ-025 Handshake definition: a transfer occurs on an edge where sig_valid_o and sig_ready_i are both high.
REQ-026 While sig_valid_o is high and no transfer occurs, sig_idata_o, sig_qdata_o and sig_last_o SHALL hold stable.
REQ-027 In RUN, on each edge where the output register is empty or transferring, and the run is not ending, the current radio sample SHALL be loaded with sig_valid_o=1.
REQ-028 In RUN, on each edge where sig_valid_o=1 and sig_ready_i=0:
- the incoming radio sample is discarded;
- overrun_o is set to 1;
- drop_cnt_o increments, saturating at 65535.
REQ-029 The sample index SHALL increment on each load and wrap to 0 after FRAME_LEN-1.
REQ-030 sig_last_o SHALL be 1 exactly when the loaded sample has index FRAME_LEN-1.
REQ-031 Frames SHALL contain exactly FRAME_LEN transferred samples; frames are never truncated.
REQ-032 A transfer with sig_last_o=1 SHALL increment frame_cnt_o, wrapping modulo 2^FBITS.
REQ-033 cfg_stop_i in RUN SHALL set the stop-pending flag.
REQ-034 The run ends at a last transfer when either holds:
- stop is pending, including a cfg_stop_i arriving on that same edge;
- the latched frame count is nonzero and the incremented frame_cnt_o equals it.
REQ-035 At run end, at that edge:
- the state returns to IDLE;
- sig_valid_o and sig_last_o go to 0;
- done_o pulses for exactly one cycle;
- busy_o drops.
REQ-036 Otherwise, a last transfer SHALL be immediately followed by index-0 loading of the next frame, with no bubble.
REQ-037 In IDLE, no radio samples are counted as dropped.
REQ-038 frame_cnt_o, overrun_o and drop_cnt_o SHALL hold their values in IDLE until the next start.

Reset
REQ-039 rst_n low at a rising edge SHALL force, regardless of state (including mid-frame):
- IDLE;
- sig_valid_o=0, sig_last_o=0, sig_idata_o=0, sig_qdata_o=0;
- busy_o=0, done_o=0;
- frame_cnt_o=0, overrun_o=0, drop_cnt_o=0;
- sample index 0 and stop-pending cleared.
REQ-040 A partial frame SHALL be abandoned on reset, and no done_o is issued for it.

Verification (FRAME_LEN=8, WIDTH=4)
REQ-041 Bounded run:
- stimulus: cfg_frames_i=3, sig_ready_i tied 1, start pulse;
- response: 24 contiguous valid cycles, sig_last_o on transfers 8, 16 and 24, done_o one cycle after the 24th transfer, frame_cnt_o=3, overrun_o=0.
REQ-042 Backpressure:
- stimulus: cfg_frames_i=1, sig_ready_i=0 for 3 cycles after the 2nd transfer;
- response: data held stable, drop_cnt_o=3, overrun_o=1, still exactly 8 transfers, last on the 8th.
REQ-043 Stop mid-frame:
- stimulus: cfg_frames_i=0, cfg_stop_i pulsed at transfer 11;
- response: run ends after transfer 16, frame_cnt_o=2, single done_o pulse.
REQ-044 Stop coinciding with last:
- stimulus: cfg_stop_i on the same edge as the transfer-8 last;
- response: run ends there, frame_cnt_o=1.
REQ-045 Reset mid-run:
- stimulus: rst_n low at transfer 5;
- response: all outputs 0 on the next cycle, no done_o;
- then a new start gives a fresh frame at index 0 with counters cleared.
REQ-046 Ignored controls:
- stimulus: start pulse during RUN, and stop pulse in IDLE;
- response: no change to the FSM state or the counters.
